// File: rtl/sccb_slave.sv
// SCCB responder: decodes 3-phase writes and 2-phase reads into a 256x8 register file; optional SCCB_SLV_TIMEOUT_EN stall timeout.
// Latency: 3 clk pad-to-decode, wr_vld 4 clk after WDATA bit 7 rise, sio_d released REL_DLY clk after last read-bit rise.
// Backpressure: none; fully slaved to the master's sio_c, and waits indefinitely for edges unless the timeout is built.
module sccb_slave #(
    parameter logic [7:0] DEV_ID      = 8'h42,
    parameter int         REL_DLY     = 40,
    parameter int         TIMEOUT_CYC = 4096
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sio_c,
    input  logic       sio_d_r,
    output logic       en_sio_d_w,
    output logic       sio_d_w,
    input  logic       host_wen,
    input  logic [7:0] host_addr,
    input  logic [7:0] host_wdata,
    output logic       wr_vld,
    output logic [7:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       rd_vld,
    output logic       err
);
    typedef enum logic [3:0] {
        S_IDLE, S_ID, S_ID_X, S_ADDR, S_ADDR_X, S_WDATA, S_RDATA, S_RDATA_NA, S_WAIT_STOP
    } state_t;

    localparam int RW = (REL_DLY > 1) ? $clog2(REL_DLY) : 1;

    state_t        state, state_n;
    logic          sc_m, sc, sc_h, sd_m, sd, sd_h;
    logic          sc_rise, sc_fall, start, stop, to_hit;
    logic [2:0]    cnt;
    logic [6:0]    rx;
    logic [7:0]    rx_byte, ptr, tx;
    logic          rnw, wr_pend;
    logic          rel_act, rel_done;
    logic [RW-1:0] rel_cnt;
    logic          id_ld, ptr_ld, wr_go, tx_ld, rel_go, rd_go;
    logic [7:0]    regs [256];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            {sc_m, sc, sc_h, sd_m, sd, sd_h} <= '1;
        end else begin
            sc_m <= sio_c;
            sc   <= sc_m;
            sc_h <= sc;
            sd_m <= sio_d_r;
            sd   <= sd_m;
            sd_h <= sd;
        end
    end

    assign sc_rise  = sc & ~sc_h;
    assign sc_fall  = ~sc & sc_h;
    assign start    = sc & sc_h & sd_h & ~sd;
    assign stop     = sc & sc_h & ~sd_h & sd;
    assign rx_byte  = {rx, sd};
    assign rel_done = rel_act && (rel_cnt == RW'(REL_DLY - 1));

`ifdef SCCB_SLV_TIMEOUT_EN
    localparam int SW = $clog2(TIMEOUT_CYC);
    logic [SW-1:0] stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall <= '0;
            err   <= 1'b0;
        end else begin
            err <= to_hit;
            if (sc_rise || sc_fall || state == S_IDLE)
                stall <= '0;
            else
                stall <= stall + SW'(1);
        end
    end

    assign to_hit = (state != S_IDLE) && (stall == SW'(TIMEOUT_CYC - 1));
`else
    logic [$clog2(TIMEOUT_CYC)-1:0] unused_stall;
    assign unused_stall = '0;
    assign to_hit       = 1'b0;
    assign err          = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_n;
    end

    // Start/stop override every state; timeout overrides both.
    always_comb begin
        state_n = state;
        id_ld   = 1'b0;
        ptr_ld  = 1'b0;
        wr_go   = 1'b0;
        tx_ld   = 1'b0;
        rel_go  = 1'b0;
        rd_go   = 1'b0;
        if (to_hit) begin
            state_n = S_IDLE;
        end else if (start) begin
            state_n = S_ID;
        end else if (stop) begin
            state_n = S_IDLE;
        end else begin
            case (state)
                S_ID: if (sc_rise && cnt == 3'd7) begin
                    id_ld   = 1'b1;
                    state_n = (rx_byte[7:1] == DEV_ID[7:1]) ? S_ID_X : S_WAIT_STOP;
                end
                S_ID_X: if (sc_rise) begin
                    if (rnw) begin
                        state_n = S_RDATA;
                        tx_ld   = 1'b1;
                    end else begin
                        state_n = S_ADDR;
                    end
                end
                S_ADDR: if (sc_rise && cnt == 3'd7) begin
                    ptr_ld  = 1'b1;
                    state_n = S_ADDR_X;
                end
                S_ADDR_X: if (sc_rise) state_n = S_WDATA;
                S_WDATA: if (sc_rise && cnt == 3'd7) begin
                    wr_go   = 1'b1;
                    state_n = S_WAIT_STOP;
                end
                S_RDATA: begin
                    if (sc_rise && cnt == 3'd7) rel_go = 1'b1;
                    if (rel_done) begin
                        rd_go   = 1'b1;
                        state_n = S_RDATA_NA;
                    end
                end
                S_RDATA_NA: if (sc_rise) state_n = S_WAIT_STOP;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            rx         <= '0;
            rnw        <= 1'b0;
            ptr        <= '0;
            tx         <= '0;
            wr_pend    <= 1'b0;
            wr_vld     <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            rd_vld     <= 1'b0;
            rel_act    <= 1'b0;
            rel_cnt    <= '0;
            en_sio_d_w <= 1'b0;
            sio_d_w    <= 1'b1;
            for (int i = 0; i < 256; i++) regs[i] <= '0;
        end else begin
            wr_pend <= wr_go;
            wr_vld  <= wr_pend;
            rd_vld  <= rd_go;
            if (sc_rise) rx <= rx_byte[6:0];
            if (start)
                cnt <= '0;
            else if (sc_rise && (state inside {S_ID, S_ADDR, S_WDATA, S_RDATA}))
                cnt <= cnt + 3'd1;
            if (id_ld)  rnw <= rx_byte[0];
            if (ptr_ld) ptr <= rx_byte;
            // SCCB write is issued last so it wins a same-address host collision.
            if (host_wen) regs[host_addr] <= host_wdata;
            if (wr_go) begin
                regs[ptr] <= rx_byte;
                wr_addr   <= ptr;
                wr_data   <= rx_byte;
            end
            if (start || stop || to_hit)
                rel_act <= 1'b0;
            else if (rel_go) begin
                rel_act <= 1'b1;
                rel_cnt <= '0;
            end else if (rel_done)
                rel_act <= 1'b0;
            else if (rel_act)
                rel_cnt <= rel_cnt + RW'(1);
            // Once the release timer runs, later falling edges belong to the master's NA bit.
            if (start || stop || to_hit || rd_go) begin
                en_sio_d_w <= 1'b0;
                sio_d_w    <= 1'b1;
            end else if (state == S_RDATA && sc_fall && !rel_act) begin
                en_sio_d_w <= 1'b1;
                sio_d_w    <= tx[7];
                tx         <= {tx[6:0], 1'b0};
            end
            if (tx_ld) tx <= regs[ptr];
        end
    end

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: bit-banged SCCB master on an open-drain pad model, scoreboard of expected writes/reads.
module tb_sccb_slave;
    localparam int Q = 25;

    logic       clk = 1'b0, rst_n = 1'b0, sio_c = 1'b1, m_d = 1'b1, host_wen = 1'b0;
    logic [7:0] host_addr = 8'h00, host_wdata = 8'h00;
    logic       sio_d_r, en_sio_d_w, sio_d_w, wr_vld, rd_vld, err;
    logic [7:0] wr_addr, wr_data;

    int checks = 0, errors = 0;
    int cyc = 0, wr_cnt = 0, rd_cnt = 0, err_cnt = 0, en_cnt = 0, err_cyc = 0;
    int obs_idx = 0;
    logic [15:0] obs_wr[$];
    logic [15:0] exp_wr[$];
    logic [7:0]  exp_rd[$];

    always #5 clk = ~clk;

    assign sio_d_r = m_d & (en_sio_d_w ? sio_d_w : 1'b1);

    sccb_slave dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .sio_c      (sio_c),
        .sio_d_r    (sio_d_r),
        .en_sio_d_w (en_sio_d_w),
        .sio_d_w    (sio_d_w),
        .host_wen   (host_wen),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .wr_vld     (wr_vld),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_vld     (rd_vld),
        .err        (err)
    );

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (wr_vld) begin
            obs_wr.push_back({wr_addr, wr_data});
            wr_cnt++;
        end
        if (rd_vld) rd_cnt++;
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
        if (en_sio_d_w) en_cnt++;
    end

    task automatic wclk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One SCCB bit; with coll set, a host write hits the same cycle as the SCCB commit.
    task automatic bit_io(input logic b, input logic coll, output logic pad, output logic en);
        wclk(Q); m_d = b;
        wclk(Q); sio_c = 1'b1;
        if (coll) begin
            wclk(2); host_wen = 1'b1;
            wclk(1); host_wen = 1'b0;
            checks++;
            if (wr_vld !== 1'b0) begin errors++; $display("FAIL wr_vld_early got %b exp 0", wr_vld); end
            wclk(1);
            checks++;
            if (wr_vld !== 1'b1) begin errors++; $display("FAIL wr_vld_lat4 got %b exp 1", wr_vld); end
            wclk(Q - 4);
        end else begin
            wclk(Q);
        end
        pad = sio_d_r;
        en  = en_sio_d_w;
        wclk(Q); sio_c = 1'b0;
    endtask

    task automatic start_c;
        m_d = 1'b1; wclk(Q); sio_c = 1'b1; wclk(Q); m_d = 1'b0; wclk(Q); sio_c = 1'b0;
    endtask

    task automatic stop_c;
        m_d = 1'b0; wclk(Q); sio_c = 1'b1; wclk(Q); m_d = 1'b1; wclk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic coll);
        logic p, e;
        for (int i = 7; i >= 0; i--) bit_io(b[i], coll && (i == 0), p, e);
    endtask

    task automatic write3(input logic [7:0] id, input logic [7:0] a, input logic [7:0] d, input logic coll);
        logic p, e;
        start_c;
        send_byte(id, 1'b0); bit_io(1'b1, 1'b0, p, e);
        send_byte(a, 1'b0);  bit_io(1'b1, 1'b0, p, e);
        send_byte(d, coll);  bit_io(1'b1, 1'b0, p, e);
        stop_c;
    endtask

    task automatic addr_phase(input logic [7:0] a);
        logic p, e;
        start_c;
        send_byte(8'h42, 1'b0); bit_io(1'b1, 1'b0, p, e);
        send_byte(a, 1'b0);     bit_io(1'b1, 1'b0, p, e);
    endtask

    task automatic read2(output logic [7:0] b, output logic [7:0] enp, output logic ex, output logic ena);
        logic p, e;
        start_c;
        send_byte(8'h43, 1'b0);
        bit_io(1'b1, 1'b0, p, ex);
        for (int i = 7; i >= 0; i--) begin
            bit_io(1'b1, 1'b0, p, e);
            b[i] = p; enp[i] = e;
        end
        bit_io(1'b1, 1'b0, p, ena);
        stop_c;
    endtask

    task automatic test_reset;
        wclk(3);
        checks++; if (en_sio_d_w !== 1'b0) begin errors++; $display("FAIL rst_en got %b exp 0", en_sio_d_w); end
        checks++; if (sio_d_w !== 1'b1) begin errors++; $display("FAIL rst_sdw got %b exp 1", sio_d_w); end
        checks++; if (wr_vld !== 1'b0) begin errors++; $display("FAIL rst_wr_vld got %b exp 0", wr_vld); end
        checks++; if (wr_addr !== 8'h00) begin errors++; $display("FAIL rst_wr_addr got %h exp 00", wr_addr); end
        checks++; if (wr_data !== 8'h00) begin errors++; $display("FAIL rst_wr_data got %h exp 00", wr_data); end
        checks++; if (rd_vld !== 1'b0) begin errors++; $display("FAIL rst_rd_vld got %b exp 0", rd_vld); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got %b exp 0", err); end
        rst_n = 1'b1;
        wclk(5);
    endtask

    task automatic test_write;
        int w0, n0;
        logic [15:0] e16;
        logic [7:0] b, enp, e8;
        logic ex, ena;
        w0 = wr_cnt; n0 = en_cnt;
        exp_wr.push_back({8'h12, 8'h80});
        write3(8'h42, 8'h12, 8'h80, 1'b0);
        wclk(5);
        e16 = exp_wr.pop_front();
        checks++;
        if (obs_idx >= obs_wr.size()) begin errors++; $display("FAIL write_obs missing exp %h", e16); end
        else begin
            if (obs_wr[obs_idx] !== e16) begin errors++; $display("FAIL write_obs got %h exp %h", obs_wr[obs_idx], e16); end
            obs_idx++;
        end
        checks++; if (wr_cnt - w0 !== 1) begin errors++; $display("FAIL write_pulses got %0d exp 1", wr_cnt - w0); end
        checks++; if (en_cnt - n0 !== 0) begin errors++; $display("FAIL write_en got %0d cycles exp 0", en_cnt - n0); end
        exp_rd.push_back(8'h80);
        read2(b, enp, ex, ena);
        e8 = exp_rd.pop_front();
        checks++; if (b !== e8) begin errors++; $display("FAIL write_readback got %h exp %h", b, e8); end
    endtask

    task automatic test_read;
        int w0, r0;
        logic [7:0] b, enp, e8;
        logic ex, ena;
        @(negedge clk); host_addr = 8'h0A; host_wdata = 8'h76; host_wen = 1'b1;
        @(negedge clk); host_wen = 1'b0;
        addr_phase(8'h0A); stop_c;
        w0 = wr_cnt; r0 = rd_cnt;
        exp_rd.push_back(8'h76);
        read2(b, enp, ex, ena);
        wclk(5);
        e8 = exp_rd.pop_front();
        checks++; if (b !== e8) begin errors++; $display("FAIL read_data got %h exp %h", b, e8); end
        checks++; if (enp !== 8'hFF) begin errors++; $display("FAIL read_en_bits got %b exp 11111111", enp); end
        checks++; if ({ex, ena} !== 2'b00) begin errors++; $display("FAIL read_en_x_na got %b exp 00", {ex, ena}); end
        checks++; if (rd_cnt - r0 !== 1) begin errors++; $display("FAIL read_pulses got %0d exp 1", rd_cnt - r0); end
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL read_no_wr got %0d exp 0", wr_cnt - w0); end
        checks++; if (en_sio_d_w !== 1'b0) begin errors++; $display("FAIL read_released got %b exp 0", en_sio_d_w); end
    endtask

    task automatic test_wrong_id;
        int w0, n0;
        logic [7:0] b, enp, e8;
        logic ex, ena;
        w0 = wr_cnt; n0 = en_cnt;
        write3(8'h60, 8'h12, 8'h11, 1'b0);
        wclk(5);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL wrongid_wr got %0d exp 0", wr_cnt - w0); end
        checks++; if (en_cnt - n0 !== 0) begin errors++; $display("FAIL wrongid_en got %0d exp 0", en_cnt - n0); end
        addr_phase(8'h12); stop_c;
        exp_rd.push_back(8'h80);
        read2(b, enp, ex, ena);
        e8 = exp_rd.pop_front();
        checks++; if (b !== e8) begin errors++; $display("FAIL wrongid_reg got %h exp %h", b, e8); end
    endtask

    task automatic test_abort;
        int w0;
        logic p, e;
        logic [15:0] e16;
        logic [7:0] b, enp, e8;
        logic ex, ena;
        w0 = wr_cnt;
        start_c;
        send_byte(8'h42, 1'b0); bit_io(1'b1, 1'b0, p, e);
        for (int i = 0; i < 4; i++) bit_io(1'b1, 1'b0, p, e);
        stop_c;
        wclk(5);
        checks++; if (wr_cnt - w0 !== 0) begin errors++; $display("FAIL abort_wr got %0d exp 0", wr_cnt - w0); end
        exp_rd.push_back(8'h80);
        read2(b, enp, ex, ena);
        e8 = exp_rd.pop_front();
        checks++; if (b !== e8) begin errors++; $display("FAIL abort_ptr got %h exp %h", b, e8); end
        exp_wr.push_back({8'h05, 8'hA5});
        write3(8'h42, 8'h05, 8'hA5, 1'b0);
        wclk(5);
        e16 = exp_wr.pop_front();
        checks++;
        if (obs_idx >= obs_wr.size()) begin errors++; $display("FAIL abort_wr_after missing exp %h", e16); end
        else begin
            if (obs_wr[obs_idx] !== e16) begin errors++; $display("FAIL abort_wr_after got %h exp %h", obs_wr[obs_idx], e16); end
            obs_idx++;
        end
        exp_rd.push_back(8'hA5);
        read2(b, enp, ex, ena);
        e8 = exp_rd.pop_front();
        checks++; if (b !== e8) begin errors++; $display("FAIL abort_readback got %h exp %h", b, e8); end
    endtask

    task automatic test_back_to_back;
        logic [15:0] e16;
        logic [7:0] b, enp, e8;
        logic ex, ena;
        addr_phase(8'h0A);
        exp_rd.push_back(8'h76);
        read2(b, enp, ex, ena);
        e8 = exp_rd.pop_front();
        checks++; if (b !== e8) begin errors++; $display("FAIL rstart_read got %h exp %h", b, e8); end
        exp_wr.push_back({8'h20, 8'h01});
        write3(8'h42, 8'h20, 8'h01, 1'b0);
        exp_wr.push_back({8'h21, 8'h02});
        write3(8'h42, 8'h21, 8'h02, 1'b0);
        wclk(5);
        for (int k = 0; k < 2; k++) begin
            e16 = exp_wr.pop_front();
            checks++;
            if (obs_idx >= obs_wr.size()) begin errors++; $display("FAIL b2b_wr missing exp %h", e16); end
            else begin
                if (obs_wr[obs_idx] !== e16) begin errors++; $display("FAIL b2b_wr got %h exp %h", obs_wr[obs_idx], e16); end
                obs_idx++;
            end
        end
    endtask

    task automatic test_collision;
        logic [15:0] e16;
        logic [7:0] b, enp, e8;
        logic ex, ena;
        host_addr = 8'h30; host_wdata = 8'h33;
        exp_wr.push_back({8'h30, 8'h5A});
        write3(8'h42, 8'h30, 8'h5A, 1'b1);
        wclk(5);
        e16 = exp_wr.pop_front();
        checks++;
        if (obs_idx >= obs_wr.size()) begin errors++; $display("FAIL coll_wr missing exp %h", e16); end
        else begin
            if (obs_wr[obs_idx] !== e16) begin errors++; $display("FAIL coll_wr got %h exp %h", obs_wr[obs_idx], e16); end
            obs_idx++;
        end
        exp_rd.push_back(8'h5A);
        read2(b, enp, ex, ena);
        e8 = exp_rd.pop_front();
        checks++; if (b !== e8) begin errors++; $display("FAIL coll_reg got %h exp %h", b, e8); end
    endtask

    task automatic test_reset_mid_read;
        logic p, e;
        logic [7:0] b, enp, e8;
        logic ex, ena;
        addr_phase(8'h0A); stop_c;
        start_c;
        send_byte(8'h43, 1'b0); bit_io(1'b1, 1'b0, p, e);
        for (int i = 0; i < 3; i++) bit_io(1'b1, 1'b0, p, e);
        wclk(10);
        checks++; if (en_sio_d_w !== 1'b1) begin errors++; $display("FAIL mid_read_driving got %b exp 1", en_sio_d_w); end
        rst_n = 1'b0;
        #1;
        checks++; if (en_sio_d_w !== 1'b0) begin errors++; $display("FAIL mid_rst_en got %b exp 0", en_sio_d_w); end
        checks++; if (sio_d_w !== 1'b1) begin errors++; $display("FAIL mid_rst_sdw got %b exp 1", sio_d_w); end
        checks++; if ({wr_addr, wr_data} !== 16'h0000) begin errors++; $display("FAIL mid_rst_wr got %h exp 0000", {wr_addr, wr_data}); end
        checks++; if ({wr_vld, rd_vld, err} !== 3'b000) begin errors++; $display("FAIL mid_rst_pulses got %b exp 000", {wr_vld, rd_vld, err}); end
        sio_c = 1'b1; m_d = 1'b1;
        wclk(5); rst_n = 1'b1; wclk(5);
        addr_phase(8'h0A); stop_c;
        exp_rd.push_back(8'h00);
        read2(b, enp, ex, ena);
        e8 = exp_rd.pop_front();
        checks++; if (b !== e8) begin errors++; $display("FAIL mid_rst_reg got %h exp %h", b, e8); end
    endtask

`ifdef SCCB_SLV_TIMEOUT_EN
    task automatic test_timeout;
        int e0, c0;
        logic p, e;
        logic [7:0] b, enp, e8;
        logic ex, ena;
        addr_phase(8'h0A); stop_c;
        start_c;
        send_byte(8'h43, 1'b0); bit_io(1'b1, 1'b0, p, e);
        for (int i = 0; i < 2; i++) bit_io(1'b1, 1'b0, p, e);
        e0 = err_cnt; c0 = cyc;
        wclk(5000);
        checks++; if (err_cnt - e0 !== 1) begin errors++; $display("FAIL timeout_err got %0d pulses exp 1", err_cnt - e0); end
        checks++;
        if (err_cyc - c0 < 4094 || err_cyc - c0 > 4102) begin
            errors++; $display("FAIL timeout_lat got %0d clk exp about 4096", err_cyc - c0);
        end
        checks++; if (en_sio_d_w !== 1'b0) begin errors++; $display("FAIL timeout_en got %b exp 0", en_sio_d_w); end
        stop_c;
        exp_rd.push_back(8'h00);
        read2(b, enp, ex, ena);
        e8 = exp_rd.pop_front();
        checks++; if (b !== e8) begin errors++; $display("FAIL timeout_recover got %h exp %h", b, e8); end
    endtask
`else
    task automatic test_no_err;
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL err_tied got %0d pulses exp 0", err_cnt); end
    endtask
`endif

    initial begin
        test_reset;
        test_write;
        test_read;
        test_wrong_id;
        test_abort;
        test_back_to_back;
        test_collision;
        test_reset_mid_read;
`ifdef SCCB_SLV_TIMEOUT_EN
        test_timeout;
`else
        test_no_err;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sccb_slave.md
# sccb_slave

SCCB responder (camera-side register model) paired with the team's `sccb` master on the same `sio_c`/`sio_d` bus. It oversamples the master's `sio_c`/`sio_d` on the system clock and decodes 3-phase writes and 2-phase write + 2-phase read sequences. It holds a 256×8 register file and drives `sio_d` during read data bits. It is used as the bench/loopback target for `sccb`-based camera configuration logic and as an on-chip register emulator.

## Interface

- `DEV_ID`, 8'h42 — write ID; read ID is `DEV_ID|1`. Bit 0 is ignored on compare.
- `REL_DLY`, 40 — clk cycles after the sampling rising edge of a read data bit (8th bit only) before `sio_d` is released.
- `TIMEOUT_CYC`, 4096 — stall limit; used only with `SCCB_SLV_TIMEOUT_EN`.

Ports:

- `clk`  in  1  system clock (25 MHz)
- `rst_n`  in  1  async reset, active low
- `sio_c`  in  1  SCCB clock from master
- `sio_d_r`  in  1  SCCB data as seen on the pad
- `en_sio_d_w`  out  1  drive enable for `sio_d`
- `sio_d_w`  out  1  drive value for `sio_d`
- `host_wen`  in  1  local register write strobe, for preload
- `host_addr`  in  8  local write address
- `host_wdata`  in  8  local write data
- `wr_vld`  out  1  1-cycle pulse when an SCCB write commits
- `wr_addr`  out  8  address of last SCCB write
- `wr_data`  out  8  data of last SCCB write
- `rd_vld`  out  1  1-cycle pulse when a read byte has been fully shifted out
- `err`  out  1  1-cycle timeout pulse; constant 0 without macro

## Operation

- **Input synchronisation:** `sio_c` and `sio_d_r` each pass through 2 flops (reset to 1), plus one history flop for edge detection. All decode uses the synchronised signals `sc`/`sd`.
- **Start:** `sd` 1→0 while `sc` is high in both the current and previous cycle. Enters ID from any state (repeated start), clears the bit counter, and releases the bus.
- **Stop:** `sd` 0→1 under the same condition. Enters IDLE from any state and releases the bus.
- **Sampling:** `sd` is shifted MSB-first on each `sc` rising edge. A 3-bit counter counts 0..7.
- **States:**
  - IDLE
  - ID (8 bits)
    - If `ID[7:1] != DEV_ID[7:1]`, go to WAIT_STOP.
    - If `ID[0]=0`, go to ID_X then ADDR.
    - If `ID[0]=1`, go to ID_X then RDATA.
  - ID_X — 1 don't-care bit, ignored.
  - ADDR (8 bits) → ADDR_X. The address pointer `ptr` is latched on the 8th rising edge.
  - ADDR_X → WDATA.
    - A 2-phase write ends here via stop.
  - WDATA (8 bits)
    - On the 8th rising edge: write `reg[ptr]`, pulse `wr_vld` the next cycle, update `wr_addr`/`wr_data`.
    - Then go to WAIT_STOP; the X bit is ignored.
  - RDATA
    - On each `sc` falling edge, assert `en_sio_d_w` and set `sio_d_w` to the next bit of the shift register, which is loaded from `reg[ptr]`.
    - The first falling edge is the one following the ID_X rising edge.
    - `REL_DLY` cycles after the 8th data rising edge: deassert `en_sio_d_w`, pulse `rd_vld`, go to RDATA_NA.
  - RDATA_NA — NA bit ignored → WAIT_STOP.
  - WAIT_STOP — ignores everything until start or stop.
- **Address pointer:** `ptr` does not auto-increment and persists across transactions. Reset value is 0.
- **Host writes:** `host_wen` writes `reg[host_addr]` immediately. If it collides with an SCCB write to the same address in the same cycle, the SCCB write wins.
- **Reset mid-operation:** all state returns to IDLE and `en_sio_d_w`=0 asynchronously. Registers clear to 0.

## Timing

- **Reset values:** `en_sio_d_w`=0, `sio_d_w`=1, `wr_vld`=0, `wr_addr`=0, `wr_data`=0, `rd_vld`=0, `err`=0.
- **Edge detect latency:** 3 clk from pad edge to decode.
- **Drive update:** 3–4 clk after the pad `sio_c` falls, well inside the master's 60-clk low phase. Data is stable before the master samples 30 clk into the high phase.
- **Write commit:** `wr_vld` goes high 4 clk after the pad rising edge of WDATA bit 7.
- **Register read:** `reg[ptr]` is read combinationally into the shift register at the ID_X rising edge.
- **Bus usage:** `sio_d_w` is meaningful only while `en_sio_d_w`=1. Its idle value is 1.
- **Glitches:** any rising edge of `sc` in IDLE or WAIT_STOP is ignored.

## Configuration

- **`SCCB_SLV_TIMEOUT_EN` defined:** a stall counter clears on every `sc` edge and counts while state ≠ IDLE.
  - On reaching `TIMEOUT_CYC`-1: go to IDLE, deassert `en_sio_d_w`, pulse `err` for 1 clk.
  - No register write occurs for a partial byte.
- **Macro undefined:** no counter is built, `err` is tied to 0, and the slave waits indefinitely for `sio_c` edges or start/stop.

## Test plan

- **3-phase write:** master writes ID 0x42, addr 0x12, data 0x80 → one `wr_vld` pulse with `wr_addr`=0x12 and `wr_data`=0x80; `reg[0x12]`=0x80; `en_sio_d_w` never 1.
- **Read:** preload `host_addr`=0x0A, `host_wdata`=0x76; master issues 2-phase write addr 0x0A, then 2-phase read ID 0x43 → slave drives bits 0,1,1,1,0,1,1,0; master `rdata`=0x76, `rdata_vld`=1; one `rd_vld` pulse; `en_sio_d_w` high for exactly the 8 data bits.
- **Wrong ID:** 3-phase write with ID 0x60 → no `wr_vld`, no register change, `en_sio_d_w`=0 throughout.
- **Abort by stop:** start, ID 0x42, 4 address bits, then stop → IDLE, no `wr_vld`, `ptr` unchanged. A following 3-phase write to 0x05 with data 0xA5 succeeds.
- **Reset mid-read:** assert `rst_n`=0 during RDATA bit 3 → `en_sio_d_w`=0 within the same cycle, all outputs at reset values, `reg[0x0A]`=0.
- **Timeout (`SCCB_SLV_TIMEOUT_EN`, `TIMEOUT_CYC`=4096):** hold `sio_c` low for 5000 clk during RDATA → one `err` pulse 4096 clk after the last edge; `en_sio_d_w`=0; state returns to IDLE.
